// File: rtl/drum_pkg.sv
// ============================================================================
//  Module      : drum_pkg
//  Description : Shared constants and types for the drum pattern path:
//                frame header default, ACK/NAK reply codes, loader state
//                encoding and the step/sample bit order of a pattern word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package drum_pkg;

    // Frame start byte used when the loader is not given another value.
    localparam logic [7:0] C_HEADER_DEFAULT = 8'hA5;

    // Reply codes sent back to the host after a frame is judged.
    localparam logic [7:0] C_ACK = 8'h06;
    localparam logic [7:0] C_NAK = 8'h15;

    // Pattern geometry: 8 steps of 4 samples, one nibble per step.
    localparam int C_STEPS         = 8;
    localparam int C_SAMPLES       = 4;
    localparam int C_PATTERN_W     = C_STEPS * C_SAMPLES;
    localparam int C_PAYLOAD_BYTES = C_PATTERN_W / 8;

    // Bit position of each sample inside a step nibble {kick, clap, hihat, snare}.
    localparam int C_BIT_SNARE = 0;
    localparam int C_BIT_HIHAT = 1;
    localparam int C_BIT_CLAP  = 2;
    localparam int C_BIT_KICK  = 3;

    // Loader frame state.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CHECK   = 2'd2
    } state_e;

    // Nibble of step 'step' (0-based) from a pattern word.
    function automatic logic [3:0] step_nibble(input logic [C_PATTERN_W-1:0] pat,
                                               input int step);
        return pat[4*step +: 4];
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_byte_accept.sv
// ============================================================================
//  Module      : rx_byte_accept
//  Description : Edge-qualified capture of bytes from the UART receiver.
//                A byte is taken when rxready is high, no ack is in flight
//                and rxready has been low since the previous take. The ack
//                pulse rxclk and byte_valid are both high for one cycle in
//                the cycle after the take, with byte_data stable.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_byte_accept (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxready,
    input  logic [7:0] rxdata,
    output logic       rxclk,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    logic       armed_q, armed_d;
    logic       rxclk_q, rxclk_d;
    logic       valid_q, valid_d;
    logic [7:0] data_q,  data_d;
    logic       w_take;

    // Decide whether this cycle carries a fresh byte and arm for the next one.
    always_comb begin
        w_take  = rxready && armed_q && !rxclk_q;
        armed_d = armed_q;
        if (!rxready) begin
            armed_d = 1'b1;
        end else if (w_take) begin
            armed_d = 1'b0;
        end
        rxclk_d = w_take;
        valid_d = w_take;
        data_d  = w_take ? rxdata : data_q;
    end

    // Register the handshake state; a level held across reset counts as new.
    always_ff @(posedge clk) begin
        if (!rst) begin
            armed_q <= 1'b1;
            rxclk_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            armed_q <= armed_d;
            rxclk_q <= rxclk_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign rxclk      = rxclk_q;
    assign byte_valid = valid_q;
    assign byte_data  = data_q;

endmodule

`default_nettype wire

// File: rtl/pattern_uart_loader.sv
// ============================================================================
//  Module      : pattern_uart_loader
//  Description : Receives framed drum patterns (HEADER, 4 payload bytes,
//                XOR checksum) from the UART receiver and commits each
//                valid frame atomically to the pattern register. Bad
//                checksums and inter-byte timeouts raise load_err.
//                Optional macro PATTERN_ECHO_EN adds an ACK/NAK reply on
//                txdata/txclk; without it those outputs are tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_uart_loader
    import drum_pkg::*;
#(
    parameter logic [7:0] HEADER  = C_HEADER_DEFAULT,
    parameter int         TIMEOUT = 2000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [7:0]             rxdata,
    input  logic                   rxready,
    output logic                   rxclk,
    output logic [C_PATTERN_W-1:0] pattern,
    output logic                   load_done,
    output logic                   load_err,
    output logic [7:0]             txdata,
    output logic                   txclk,
    input  logic                   txready
);

    localparam int C_TIMER_W = $clog2(TIMEOUT + 1);

    logic       w_byte_valid;
    logic [7:0] w_byte;
    logic       w_timeout;

    state_e                 state_q,     state_d;
    logic [1:0]             idx_q,       idx_d;
    logic [7:0]             csum_q,      csum_d;
    logic [C_PATTERN_W-1:0] shadow_q,    shadow_d;
    logic [C_PATTERN_W-1:0] pattern_q,   pattern_d;
    logic [C_TIMER_W-1:0]   timer_q,     timer_d;
    logic                   load_done_q, load_done_d;
    logic                   load_err_q,  load_err_d;

    rx_byte_accept u_rx_byte_accept (
        .clk        (clk),
        .rst        (rst),
        .rxready    (rxready),
        .rxdata     (rxdata),
        .rxclk      (rxclk),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte)
    );

    assign w_timeout = (timer_q == C_TIMER_W'(TIMEOUT - 1));

    // Frame parser: a byte always wins over a timeout in the same cycle.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        shadow_d    = shadow_q;
        timer_d     = timer_q;
        pattern_d   = pattern_q;
        load_done_d = 1'b0;
        load_err_d  = 1'b0;

        if (!en) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            timer_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    timer_d = '0;
                    if (w_byte_valid && (w_byte == HEADER)) begin
                        state_d  = S_PAYLOAD;
                        idx_d    = 2'd0;
                        csum_d   = 8'h00;
                        shadow_d = '0;
                    end
                end
                S_PAYLOAD: begin
                    if (w_byte_valid) begin
                        // Low nibble is the earlier step of the pair.
                        shadow_d[{idx_q, 3'b000} +: 4] = w_byte[3:0];
                        shadow_d[{idx_q, 3'b100} +: 4] = w_byte[7:4];
                        csum_d  = csum_q ^ w_byte;
                        timer_d = '0;
                        if (idx_q == 2'(C_PAYLOAD_BYTES - 1)) begin
                            state_d = S_CHECK;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else if (w_timeout) begin
                        load_err_d = 1'b1;
                        state_d    = S_IDLE;
                        shadow_d   = '0;
                        timer_d    = '0;
                    end else begin
                        timer_d = timer_q + C_TIMER_W'(1);
                    end
                end
                S_CHECK: begin
                    if (w_byte_valid) begin
                        timer_d = '0;
                        state_d = S_IDLE;
                        if (w_byte == csum_q) begin
                            pattern_d   = shadow_q;
                            load_done_d = 1'b1;
                        end else begin
                            load_err_d  = 1'b1;
                        end
                    end else if (w_timeout) begin
                        load_err_d = 1'b1;
                        state_d    = S_IDLE;
                        shadow_d   = '0;
                        timer_d    = '0;
                    end else begin
                        timer_d = timer_q + C_TIMER_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Frame state, committed pattern and result pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            csum_q      <= 8'h00;
            shadow_q    <= '0;
            pattern_q   <= '0;
            timer_q     <= '0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            shadow_q    <= shadow_d;
            pattern_q   <= pattern_d;
            timer_q     <= timer_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign pattern   = pattern_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

`ifdef PATTERN_ECHO_EN
    logic       tx_pending_q, tx_pending_d;
    logic [7:0] txdata_q,     txdata_d;
    logic       txclk_q,      txclk_d;

    // Single-entry reply slot; a fresh verdict replaces an unsent one.
    always_comb begin
        tx_pending_d = tx_pending_q;
        txdata_d     = txdata_q;
        txclk_d      = 1'b0;
        if (load_done_d) begin
            txdata_d     = C_ACK;
            tx_pending_d = 1'b1;
        end else if (load_err_d) begin
            txdata_d     = C_NAK;
            tx_pending_d = 1'b1;
        end else if (tx_pending_q && txready) begin
            txclk_d      = 1'b1;
            tx_pending_d = 1'b0;
        end
    end

    // Reply byte and strobe registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_pending_q <= 1'b0;
            txdata_q     <= 8'h00;
            txclk_q      <= 1'b0;
        end else begin
            tx_pending_q <= tx_pending_d;
            txdata_q     <= txdata_d;
            txclk_q      <= txclk_d;
        end
    end

    assign txdata = txdata_q;
    assign txclk  = txclk_q;
`else
    logic w_unused_txready;

    assign w_unused_txready = txready;
    assign txdata           = 8'h00;
    assign txclk            = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pattern_uart_loader.sv
// ============================================================================
//  Module      : tb_pattern_uart_loader
//  Description : Self-checking bench for pattern_uart_loader. A frame-level
//                reference model predicts pattern, commit and error counts
//                from the byte stream; directed and random frames exercise
//                commit, bad checksum, timeout, garbage, reset and enable.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pattern_uart_loader;

    localparam int         TIMEOUT = 100;
    localparam logic [7:0] HDR     = 8'hA5;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        en      = 1'b1;
    logic        rxready = 1'b0;
    logic        txready = 1'b1;
    logic [7:0]  rxdata  = 8'h00;
    wire         rxclk;
    wire         load_done;
    wire         load_err;
    wire         txclk;
    wire [31:0]  pattern;
    wire [7:0]   txdata;

    always #5 clk = ~clk;

    pattern_uart_loader #(
        .HEADER  (HDR),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rxdata    (rxdata),
        .rxready   (rxready),
        .rxclk     (rxclk),
        .pattern   (pattern),
        .load_done (load_done),
        .load_err  (load_err),
        .txdata    (txdata),
        .txclk     (txclk),
        .txready   (txready)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Cycle counter and output monitor
    // ------------------------------------------------------------------
    int          cyc = 0;
    int          ack_cnt = 0, done_cnt = 0, err_cnt = 0;
    int          last_ack_cyc = 0, last_done_cyc = 0, last_err_cyc = 0;
    int          long_ack = 0, leak = 0, both = 0, tx_bad = 0;
    logic [31:0] pat_at_done = 32'h0;
    logic [31:0] prev_pat = 32'h0;
    logic        prev_rxclk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (rxclk) begin
                ack_cnt++;
                last_ack_cyc = cyc;
                if (prev_rxclk) long_ack++;
            end
            if (load_done) begin
                done_cnt++;
                last_done_cyc = cyc;
                pat_at_done   = pattern;
            end
            if (load_err) begin
                err_cnt++;
                last_err_cyc = cyc;
            end
            if (load_done && load_err) both++;
            if ((pattern != prev_pat) && !load_done) leak++;
`ifndef PATTERN_ECHO_EN
            if ((txdata != 8'h00) || txclk) tx_bad++;
`endif
        end
        prev_rxclk = rxclk;
        prev_pat   = pattern;
    end

    // ------------------------------------------------------------------
    // Frame-level reference model
    // ------------------------------------------------------------------
    bit          in_frame = 0;
    logic [7:0]  fq[$];
    logic [31:0] exp_pattern = 32'h0;
    int          exp_done = 0;
    int          exp_err  = 0;

    function automatic void model_byte(input logic [7:0] b);
        logic [7:0] cs;
        if (!in_frame) begin
            if (b == HDR) begin
                in_frame = 1;
                fq.delete();
            end
        end else begin
            fq.push_back(b);
            if (fq.size() == 5) begin
                cs = fq[0] ^ fq[1] ^ fq[2] ^ fq[3];
                if (fq[4] == cs) begin
                    exp_pattern = {fq[3], fq[2], fq[1], fq[0]};
                    exp_done++;
                end else begin
                    exp_err++;
                end
                in_frame = 0;
            end
        end
    endfunction

    function automatic void model_timeout();
        if (in_frame) exp_err++;
        in_frame = 0;
    endfunction

    // ------------------------------------------------------------------
    // Host-side drivers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got;
        got     = 0;
        rxdata  = b;
        rxready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rxclk) begin
                got = 1;
                break;
            end
        end
        check_val("ack", 32'(got), 32'd1);
        step();
        rxready = 1'b0;
        if (en) model_byte(b);
        step();
        repeat (gap) step();
    endtask

    task automatic send_frame(input logic [31:0] pl, input logic [7:0] cs_flip, input int maxgap);
        logic [7:0] cs;
        cs = pl[7:0] ^ pl[15:8] ^ pl[23:16] ^ pl[31:24] ^ cs_flip;
        send_byte(HDR, $urandom_range(0, maxgap));
        for (int k = 0; k < 4; k++) send_byte(pl[8*k +: 8], $urandom_range(0, maxgap));
        send_byte(cs, $urandom_range(0, maxgap));
    endtask

    task automatic check_state(input string tag);
        repeat (3) step();
        check_val({tag, "_pattern"}, pattern, exp_pattern);
        check_val({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
        check_val({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
    endtask

    // Hard stop if something wedges the stimulus.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int a0, e0, d0, delay, bad;
        logic [31:0] pl;
        logic [7:0]  flip;

        // Reset state
        repeat (3) step();
        check_val("rst_pattern", pattern, 32'h0);
        check_val("rst_pulses", {29'h0, load_done, load_err, rxclk}, 32'h0);
        check_val("rst_tx", {23'h0, txclk, txdata}, 32'h0);
        rst = 1'b1;
        step();

        // Reference frame
        a0 = ack_cnt;
        send_frame(32'h87654321, 8'h00, 2);
        check_state("frameA");
        check_val("frameA_value", pattern, 32'h87654321);
        check_val("frameA_acks", 32'(ack_cnt - a0), 32'd6);
        check_val("frameA_latency", 32'(last_done_cyc - last_ack_cyc), 32'd1);
        check_val("frameA_pat_at_done", pat_at_done, 32'h87654321);

        // Bad checksum, then a good frame
        send_frame(32'h87654321, 8'h01, 2);
        check_state("badcs");
        check_val("badcs_hold", pattern, 32'h87654321);
        send_frame(32'h0F1E2D3C, 8'h00, 1);
        check_state("after_badcs");

        // Inter-byte timeout
        send_byte(HDR, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        e0 = err_cnt;
        d0 = done_cnt;
        for (int i = 0; i < TIMEOUT + 20; i++) begin
            step();
            if (err_cnt != e0) break;
        end
        check_val("timeout_fired", 32'(err_cnt - e0), 32'd1);
        check_val("timeout_no_done", 32'(done_cnt - d0), 32'd0);
        delay = last_err_cyc - last_ack_cyc;
        check_val("timeout_delay_ok", 32'((delay >= TIMEOUT) && (delay <= TIMEOUT + 2)), 32'd1);
        model_timeout();
        check_state("timeout");
        send_frame(32'hCAFE0123, 8'h00, 2);
        check_state("after_timeout");

        // Garbage before header, header value inside payload
        send_byte(8'h00, 1);
        send_byte(8'hFF, 1);
        send_frame(32'h12A534A5, 8'h00, 1);
        check_state("hdr_in_payload");
        check_val("hdr_in_payload_value", pattern, 32'h12A534A5);

        // Reset in the middle of a payload
        send_byte(HDR, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        rst = 1'b0;
        in_frame = 0;
        exp_pattern = 32'h0;
        repeat (3) step();
        check_val("midrst_pattern", pattern, 32'h0);
        rst = 1'b1;
        check_state("midrst");
        send_frame(32'h76543210, 8'h00, 2);
        check_state("after_midrst");

        // Enable dropped during a frame
        send_byte(HDR, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        en = 1'b0;
        in_frame = 0;
        a0 = ack_cnt;
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        send_byte(8'h04, 0);
        check_val("en_off_acks", 32'(ack_cnt - a0), 32'd3);
        en = 1'b1;
        check_state("en_off");
        send_frame(32'h9ABCDEF0, 8'h00, 2);
        check_state("after_en_off");

        // Random frames
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 2)) begin
                flip = 8'($urandom_range(0, 255));
                if (flip == HDR) flip = 8'h00;
                send_byte(flip, $urandom_range(0, 3));
            end
            pl = $urandom;
            if ($urandom_range(0, 3) == 0) pl[15:8] = HDR;
            flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            send_frame(pl, flip, 5);
            check_state("rand");
            if (flip == 8'h00) begin
                check_val("rand_latency", 32'(last_done_cyc - last_ack_cyc), 32'd1);
            end
        end

`ifdef PATTERN_ECHO_EN
        // Held reply while the transmitter is busy
        txready = 1'b0;
        send_frame(32'h24681357, 8'h00, 1);
        check_state("echo");
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((txdata != 8'h06) || txclk) bad++;
        end
        check_val("echo_hold", 32'(bad), 32'd0);
        check_val("echo_data", {24'h0, txdata}, 32'h06);
        step();
        txready = 1'b1;
        @(negedge clk);
        check_val("echo_txclk_pre", {31'h0, txclk}, 32'd0);
        @(negedge clk);
        check_val("echo_txclk", {31'h0, txclk}, 32'd1);
        @(negedge clk);
        check_val("echo_txclk_post", {31'h0, txclk}, 32'd0);
        step();
`else
        bad = 0;
        check_val("tx_tied_low", 32'(tx_bad + bad), 32'd0);
`endif

        check_val("ack_width", 32'(long_ack), 32'd0);
        check_val("no_leak", 32'(leak), 32'd0);
        check_val("no_double_pulse", 32'(both), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
